// File: rtl/sliced_accumulator_pkg.sv
// Shared definitions for the sliced accumulator.
//   op_e    : operation encodings on the 2-bit op port
//   state_e : control FSM states
//   seg7    : nibble -> active-low 7-segment pattern {g..a}, segment a = bit 0
package sliced_accumulator_pkg;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sliced_accumulator_hex.sv
// hex_decoder: one nibble to active-low 7-segment pattern {g..a}.
//   nibble in  4  digit value
//   seg    out 7  segments, a = bit 0, low = lit
module hex_decoder
  import sliced_accumulator_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = seg7(nibble);
endmodule

// File: rtl/sliced_accumulator_slice_adder.sv
// Ripple-carry building blocks for the sliced accumulator.
//   full_adder  : one-bit full adder (a, b, c_in -> s, c_out)
//   slice_adder : SLICE-bit ripple chain of full_adder instances
//     a, b   in  SLICE  addends
//     c_in   in  1      carry into bit 0
//     s      out SLICE  sum
//     c_out  out 1      carry out of the top bit
//     c_msb  out 1      carry into the top bit (overflow = c_msb ^ c_out)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);
  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module slice_adder #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             c_in,
  output logic [SLICE-1:0] s,
  output logic             c_out,
  output logic             c_msb
);
  logic [SLICE:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .c_in (c[i]),
      .s    (s[i]),
      .c_out(c[i+1])
    );
  end

  assign c_out = c[SLICE];
  assign c_msb = c[SLICE-1];
endmodule

// File: rtl/sliced_accumulator.sv
// sliced_accumulator: multi-cycle accumulator adding SLICE bits per clock.
//   CLOCK_50 in  1          clock, rising edge
//   reset    in  1          synchronous, active-high
//   start    in  1          op request, sampled only in IDLE
//   op       in  2          00 ADD, 01 SUB, 10 LOAD, 11 CLEAR
//   data_in  in  WIDTH      operand, captured on accepted start
//   c_in     in  1          carry-in for ADD
//   acc      out WIDTH      accumulator (partial during RUN)
//   c_out    out 1          carry out of MSB of last ADD/SUB
//   overflow out 1          signed overflow of last ADD/SUB
//   busy     out 1          high in RUN
//   done     out 1          one-cycle completion pulse
//   hex      out 7*WIDTH/4  active-low 7-seg per nibble, nibble k at [7k+6:7k]
module sliced_accumulator
  import sliced_accumulator_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   start,
  input  logic [1:0]             op,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   c_in,
  output logic [WIDTH-1:0]       acc,
  output logic                   c_out,
  output logic                   overflow,
  output logic                   busy,
  output logic                   done,
  output logic [7*WIDTH/4-1:0]   hex
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int NDIG   = WIDTH / 4;

  state_e           state_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] b_q;       // operand, already inverted for SUB
  logic             carry_q;   // carry between slices
  logic [CW-1:0]    cnt_q;
  logic             c_out_q, ovf_q;

  logic [SLICE-1:0] a_sl, b_sl, s_sl;
  logic             sl_co, sl_cm, last_sl;

  // Slice mux: current slice of acc and operand feeds the single adder.
  assign a_sl    = acc_q[cnt_q*SLICE +: SLICE];
  assign b_sl    = b_q[cnt_q*SLICE +: SLICE];
  assign last_sl = (cnt_q == CW'(NSLICE - 1));

  slice_adder #(.SLICE(SLICE)) u_slice (
    .a    (a_sl),
    .b    (b_sl),
    .c_in (carry_q),
    .s    (s_sl),
    .c_out(sl_co),
    .c_msb(sl_cm)
  );

  // Slice demux: write the sum back into the slice just processed.
  always_comb begin
    acc_d = acc_q;
    acc_d[cnt_q*SLICE +: SLICE] = s_sl;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            case (op_e'(op))
              OP_ADD: begin
                b_q     <= data_in;
                carry_q <= c_in;
                cnt_q   <= '0;
                state_q <= ST_RUN;
              end
              OP_SUB: begin
                // a - b = a + ~b + 1
                b_q     <= ~data_in;
                carry_q <= 1'b1;
                cnt_q   <= '0;
                state_q <= ST_RUN;
              end
              OP_LOAD: begin
                acc_q   <= data_in;
                c_out_q <= 1'b0;
                ovf_q   <= 1'b0;
                state_q <= ST_DONE;
              end
              default: begin
                acc_q   <= '0;
                c_out_q <= 1'b0;
                ovf_q   <= 1'b0;
                state_q <= ST_DONE;
              end
            endcase
          end
        end
        ST_RUN: begin
          acc_q   <= acc_d;
          carry_q <= sl_co;
          cnt_q   <= cnt_q + CW'(1);
          if (last_sl) begin
            c_out_q <= sl_co;
            ovf_q   <= sl_cm ^ sl_co;
            state_q <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign acc      = acc_q;
  assign c_out    = c_out_q;
  assign overflow = ovf_q;
  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);

  for (genvar k = 0; k < NDIG; k++) begin : g_hex
    hex_decoder u_hex (
      .nibble(acc_q[4*k +: 4]),
      .seg   (hex[7*k +: 7])
    );
  end

endmodule

// File: tb/tb_sliced_accumulator.sv
module tb_sliced_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [7:0]  data_in;
  logic        c_in;
  logic [7:0]  acc;
  logic        c_out, overflow, busy, done;
  logic [13:0] hex;

  sliced_accumulator #(.WIDTH(8), .SLICE(4)) dut (
    .CLOCK_50(clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .data_in (data_in),
    .c_in    (c_in),
    .acc     (acc),
    .c_out   (c_out),
    .overflow(overflow),
    .busy    (busy),
    .done    (done),
    .hex     (hex)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] acc;
    logic       co;
    logic       ov;
    int         lat;
    int         nbusy;
    int         issue_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   busy_cnt = 0;

  // Reference 7-seg table, active-low {g..a}
  logic [6:0] SEG [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: pops the scoreboard whenever done is seen.
  always @(negedge clk) begin
    if (reset) busy_cnt = 0;
    else if (busy) busy_cnt++;
    if (done && !reset) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: done seen with no operation pending, acc=0x%0h", acc);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, ".acc"}, 32'(acc), 32'(mon_e.acc));
        chk({mon_e.name, ".c_out"}, 32'(c_out), 32'(mon_e.co));
        chk({mon_e.name, ".overflow"}, 32'(overflow), 32'(mon_e.ov));
        chk({mon_e.name, ".latency"}, 32'(cyc - mon_e.issue_cyc), 32'(mon_e.lat));
        chk({mon_e.name, ".busy_cycles"}, 32'(busy_cnt), 32'(mon_e.nbusy));
        chk({mon_e.name, ".hex"}, 32'(hex), 32'({SEG[mon_e.acc[7:4]], SEG[mon_e.acc[3:0]]}));
      end
      busy_cnt = 0;
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 20 && (busy || done); i++) @(negedge clk);
    if (busy || done) chk("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  // Issue one op and queue its expected result; poke pulses a second
  // start (LOAD 0xEE) during RUN, which must be ignored.
  task automatic issue(input string name, input logic [1:0] o, input logic [7:0] d,
                       input logic ci, input logic [7:0] ea, input logic eco,
                       input logic eov, input bit poke);
    exp_t e;
    wait_idle();
    @(posedge clk); #1;
    e.name = name; e.acc = ea; e.co = eco; e.ov = eov;
    e.lat = o[1] ? 1 : 3;
    e.nbusy = o[1] ? 0 : 2;
    e.issue_cyc = cyc;
    sb.push_back(e);
    start = 1'b1; op = o; data_in = d; c_in = ci;
    @(posedge clk); #1;
    start = 1'b0; data_in = ~d; c_in = ~ci;
    if (poke) begin
      start = 1'b1; op = 2'b10; data_in = 8'hEE;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s.timeout: done never seen, pending=%0d required=0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; data_in = 8'h00; c_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset.acc", 32'(acc), 32'h00);
    chk("reset.c_out", 32'(c_out), 32'd0);
    chk("reset.overflow", 32'(overflow), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.hex", 32'(hex), 32'h2040);

    // 1. LOAD 0x7F
    issue("t1_load7f", 2'b10, 8'h7F, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0);
    // 2. ADD 0x01
    issue("t2_add01", 2'b00, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    // 3. LOAD 0x80, ADD 0x80
    issue("t3_load80", 2'b10, 8'h80, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0);
    issue("t3_add80", 2'b00, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    // 4. LOAD 0x05 (flags clear), SUB 0x07
    issue("t4_load05", 2'b10, 8'h05, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0);
    issue("t4_sub07", 2'b01, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0);
    // 5. LOAD 0xFF, ADD 0x00 c_in=1
    issue("t5_loadff", 2'b10, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
    issue("t5_add00ci", 2'b00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    // CLEAR after a flag-setting op; SUB with c_in=1 (ignored)
    issue("t7_loada5", 2'b10, 8'hA5, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
    issue("t7_add5b", 2'b00, 8'h5B, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    issue("t7_clear", 2'b11, 8'h99, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    issue("t7_sub80", 2'b01, 8'h80, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0);
    // 6a. mid-RUN start ignored
    issue("t6_load10", 2'b10, 8'h10, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0);
    issue("t6_add22_poke", 2'b00, 8'h22, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
    // 6b. reset asserted during RUN, flags set beforehand
    issue("t6_load80", 2'b10, 8'h80, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0);
    issue("t6_add80", 2'b00, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    wait_idle();
    @(posedge clk); #1;
    start = 1'b1; op = 2'b00; data_in = 8'h01; c_in = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("t6_rst.busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t6_rst.acc", 32'(acc), 32'h00);
    chk("t6_rst.busy", 32'(busy), 32'd0);
    chk("t6_rst.done", 32'(done), 32'd0);
    chk("t6_rst.c_out", 32'(c_out), 32'd0);
    chk("t6_rst.overflow", 32'(overflow), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("t6_rst.idle_busy", 32'(busy), 32'd0);
    issue("t6_after_rst", 2'b10, 8'h3C, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
